// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_tx_pkg
// Purpose : Shared types and constants for the USB transmit bit timer.
//           Holds the timer state encoding, the byte/SYNC bit counts and the
//           default number of clocks per USB bit period.
// Ports   : none (package)
// Options : USB_TX_SYNC_EN (used by usb_tx_timer) enables the SYNC state.
// Revision: 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    localparam int USB_BITS_PER_BYTE        = 8;
    localparam int USB_SYNC_BITS            = 8;
    localparam int USB_CLKS_PER_BIT_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_BIT  = 3'd2,
        ST_EOP  = 3'd3,
        ST_DONE = 3'd4
    } usb_tx_state_e;

endpackage : usb_tx_pkg
`default_nettype wire

// File: rtl/usb_bit_period_counter.sv
`default_nettype none
// ============================================================================
// Module  : usb_bit_period_counter
// Purpose : Modulo-CLKS_PER_BIT counter that marks the last clock of each
//           USB bit period.
// Ports   : clk    - system clock
//           rst    - synchronous active-low reset
//           clr_i  - force the count to zero (takes priority over en_i)
//           en_i   - advance the count by one, wrapping after CLKS_PER_BIT-1
//           tc_o   - high while the count sits at CLKS_PER_BIT-1
// Revision: 1.0 - initial release
// ============================================================================
module usb_bit_period_counter #(
    parameter int CLKS_PER_BIT = 32,
    parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            // Explicit wrap so non-power-of-two periods stay exact.
            count_d = (count_q == c_LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == c_LAST);

endmodule : usb_bit_period_counter
`default_nettype wire

// File: rtl/usb_tx_timer.sv
`default_nettype none
// ============================================================================
// Module  : usb_tx_timer
// Purpose : Bit-period timing generator for the USB transmit path. Emits a
//           tick at the end of every bit period, a shift strobe for each real
//           data bit, inserts stuffed-bit periods on request from the encoder,
//           requests bytes from the packet source and times the EOP.
// Ports   : clk          - system clock
//           rst          - synchronous active-low reset
//           tx_start_i   - begin a packet (honoured only in IDLE)
//           tx_last_i    - current byte is the last one (used at byte end)
//           stuff_next_i - next period is a stuffed bit (used at ticks in BIT)
//           bit_tick_o   - end of every SYNC/BIT/EOP period
//           data_shift_o - end of every non-stuffed data period
//           byte_load_o  - present the next byte to the shift register
//           stuffing_o   - current period is a stuffed bit
//           eop_active_o - EOP periods
//           tx_busy_o    - SYNC, BIT or EOP in progress
//           tx_done_o    - one-cycle pulse when the packet completes
// Options : USB_TX_SYNC_EN - when defined, 8 SYNC periods precede the first
//           byte; otherwise the packet source supplies SYNC as data.
// Revision: 1.0 - initial release
// ============================================================================
module usb_tx_timer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT_DEFAULT,
    parameter int EOP_BITS     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_start_i,
    input  logic tx_last_i,
    input  logic stuff_next_i,
    output logic bit_tick_o,
    output logic data_shift_o,
    output logic byte_load_o,
    output logic stuffing_o,
    output logic eop_active_o,
    output logic tx_busy_o,
    output logic tx_done_o
);

    localparam int              EOP_W      = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
    localparam logic [EOP_W-1:0] c_EOP_LAST = EOP_W'(EOP_BITS - 1);
    localparam logic [2:0]       c_BIT_LAST = 3'(USB_BITS_PER_BYTE - 1);
`ifdef USB_TX_SYNC_EN
    localparam logic [2:0]       c_SYNC_LAST = 3'(USB_SYNC_BITS - 1);
`endif

    usb_tx_state_e    state_q;
    logic [2:0]       bit_cnt_q;
    logic [EOP_W-1:0] eop_cnt_q;
    logic             stuff_q;
    // Set while a stuffed period follows the last data bit of a byte, so the
    // byte-end decision is taken when that stuffed run finishes.
    logic             end_pend_q;
    logic             byte_load_q;

    logic w_active;
    logic w_tc;
    logic w_tick;
    logic w_bit_tick;
    logic w_byte_end;

    assign w_active   = (state_q == ST_SYNC) || (state_q == ST_BIT) || (state_q == ST_EOP);
    assign w_tick     = w_active && w_tc;
    assign w_bit_tick = w_tick && (state_q == ST_BIT);

    // Byte ends at a tick with no further stuffing requested, either right
    // after data bit 7 or at the end of the stuffed run that followed it.
    assign w_byte_end = w_bit_tick && !stuff_next_i &&
                        ((stuff_q && end_pend_q) || (!stuff_q && (bit_cnt_q == c_BIT_LAST)));

    usb_bit_period_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_period_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!w_active),
        .en_i  (w_active),
        .tc_o  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            eop_cnt_q   <= '0;
            stuff_q     <= 1'b0;
            end_pend_q  <= 1'b0;
            byte_load_q <= 1'b0;
        end else begin
            byte_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q  <= '0;
                    eop_cnt_q  <= '0;
                    stuff_q    <= 1'b0;
                    end_pend_q <= 1'b0;
                    if (tx_start_i) begin
`ifdef USB_TX_SYNC_EN
                        state_q     <= ST_SYNC;
`else
                        state_q     <= ST_BIT;
                        byte_load_q <= 1'b1;
`endif
                    end
                end
`ifdef USB_TX_SYNC_EN
                ST_SYNC: begin
                    if (w_tick) begin
                        if (bit_cnt_q == c_SYNC_LAST) begin
                            state_q     <= ST_BIT;
                            bit_cnt_q   <= '0;
                            byte_load_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`endif
                ST_BIT: begin
                    if (w_byte_end) begin
                        stuff_q    <= 1'b0;
                        end_pend_q <= 1'b0;
                        if (tx_last_i) begin
                            state_q   <= ST_EOP;
                            eop_cnt_q <= '0;
                        end else begin
                            bit_cnt_q   <= '0;
                            byte_load_q <= 1'b1;
                        end
                    end else if (w_bit_tick) begin
                        if (stuff_q) begin
                            // Stuffed period ends; bit_cnt holds across it.
                            stuff_q <= stuff_next_i;
                        end else if (bit_cnt_q != c_BIT_LAST) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            stuff_q   <= stuff_next_i;
                        end else begin
                            // Last data bit followed by a stuffed bit.
                            stuff_q    <= 1'b1;
                            end_pend_q <= 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (w_tick) begin
                        if (eop_cnt_q == c_EOP_LAST) begin
                            state_q <= ST_DONE;
                        end else begin
                            eop_cnt_q <= eop_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bit_tick_o   = w_tick;
    assign data_shift_o = w_bit_tick && !stuff_q;
    assign byte_load_o  = byte_load_q;
    assign stuffing_o   = stuff_q;
    assign eop_active_o = (state_q == ST_EOP);
    assign tx_busy_o    = w_active;
    assign tx_done_o    = (state_q == ST_DONE);

endmodule : usb_tx_timer
`default_nettype wire
